rfu_scoreboard: RTL and testbench
=================================

RFU_SCOREBOARD -- requirements
Module: rfu_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of issued, not-yet-retired instructions tracked (power of two, 2..8).
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports issue_valid_i (in, 1), issue_rd_i (in, 5), issue_gr_we_i (in, 1), issue_csr_addr_i (in, 12) and issue_csr_we_i (in, 1), which describe an instruction leaving the RFU into the EXU.
REQ-005 SHALL have port issue_ready_o, output, 1, meaning a push can be accepted this cycle.
REQ-006 SHALL have port commit_valid_i, input, 1, meaning the oldest tracked instruction retires in WBU this cycle.
REQ-007 SHALL have port flush_all_i, input, 1, meaning an exception or mret flush that kills every in-flight instruction.
REQ-008 SHALL have query ports q_rs1_i (in, 5), q_rs1_re_i (in, 1), q_rs2_i (in, 5), q_rs2_re_i (in, 1), q_csr_addr_i (in, 12) and q_csr_re_i (in, 1).
REQ-009 SHALL have port stall_o, output, 1, meaning a query operand has a pending write.
REQ-010 SHALL have port count_o, output, $clog2(DEPTH)+1, giving the number of occupied entries.
REQ-011 SHALL have port err_o, output, 1, a sticky protocol-error flag.

Function
REQ-012 SHALL hold an in-order FIFO of DEPTH entries, each {valid, rd, gr_we, csr_addr, csr_we}, with head and tail pointers wrapping modulo DEPTH.
REQ-013 SHALL push an entry when issue_valid_i && issue_ready_o; the entry SHALL be visible to stall_o from the next cycle (1-cycle latency).
REQ-014 SHALL store gr_we as 0 when issue_rd_i==0, so that x0 never creates a hazard.
REQ-015 SHALL pop the head entry when commit_valid_i is high and count_o>0.
REQ-016 SHALL drive issue_ready_o = (count_o<DEPTH) || commit_valid_i, so that push and pop in the same cycle are allowed when full; count_o is then unchanged.
REQ-017 SHALL perform push and pop in the same cycle when non-empty: both pointers advance and count_o is unchanged.
REQ-018 SHALL, on push and pop in the same cycle when empty, ignore the pop, accept the push, and set err_o.
REQ-019 SHALL, on commit_valid_i when count_o==0, leave state unchanged and set err_o.
REQ-020 SHALL, on issue_valid_i while issue_ready_o==0, drop the push and set err_o.
REQ-021 SHALL drive stall_o combinationally, high iff some valid entry satisfies (gr_we && q_rs1_re_i && rd==q_rs1_i && q_rs1_i!=0), (gr_we && q_rs2_re_i && rd==q_rs2_i && q_rs2_i!=0), or (csr_we && q_csr_re_i && csr_addr==q_csr_addr_i).
REQ-022 SHALL treat an entry being popped this cycle as still pending for stall_o, because the write is not readable until the next edge.
REQ-023 SHALL, on flush_all_i, clear all entries and pointers and set count_o to 0 at the next edge, ignoring a same-cycle issue or commit.
REQ-024 SHALL give flush_all_i no effect on err_o.
REQ-025 SHALL keep count_o as a registered value that never exceeds DEPTH.

Reset
REQ-026 SHALL, on reset, clear all valid bits, head, tail and err_o, and set count_o to 0.
REQ-027 SHALL give reset priority over flush_all_i, issue and commit.
REQ-028 SHALL drive stall_o=0 and issue_ready_o=1 in the cycle after reset; a reset asserted mid-operation discards all entries.
REQ-029 SHALL not reset entry payload fields; validity is gated by the valid bits only.

Structure
REQ-030 SHALL take the register-index width (5) and CSR address width (12) as macros from the shared riscv_param.vh header, with no local redefinition.
REQ-031 SHALL instantiate one sub-module, rfu_sb_match, per entry; it is a combinational comparator producing that entry's hazard bit, and the bits are OR-reduced into stall_o.
REQ-032 SHALL keep all sequential logic in rfu_scoreboard.

Verification
REQ-033 SHALL cover: issue rd=5 gr_we=1, next cycle query rs1=5 re=1 -> stall_o=1; after commit, next cycle -> stall_o=0.
REQ-034 SHALL cover: issue rd=0 gr_we=1, query rs2=0 -> stall_o=0 and count_o=1.
REQ-035 SHALL cover: issue csr 0x341 csr_we=1, query csr 0x341 re=1 -> stall_o=1; query csr 0x300 -> stall_o=0.
REQ-036 SHALL cover: 4 issues with DEPTH=4 -> issue_ready_o=0; issue plus commit in the same cycle -> accepted, count_o stays 4, oldest rd gone; extra issue alone -> dropped, err_o=1.
REQ-037 SHALL cover: 3 entries plus flush_all_i with simultaneous issue -> next cycle count_o=0 and stall_o=0 for all queries.
REQ-038 SHALL cover: commit on empty -> err_o=1 and count_o=0; then reset -> err_o=0.

Source files
------------

// File: rtl/rfu_scoreboard_pkg.sv
// Types and helpers shared by the RFU write-hazard scoreboard.
package rfu_scoreboard_pkg;
`include "riscv_param.vh"

  localparam int unsigned REG_AW = `RV_REG_AW;
  localparam int unsigned CSR_AW = `RV_CSR_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              gr_we;
    logic [CSR_AW-1:0] csr_addr;
    logic              csr_we;
  } sb_entry_t;

  // Writes to x0 are architecturally discarded, so they never create a hazard.
  function automatic sb_entry_t make_entry(input logic [REG_AW-1:0] rd,
                                           input logic              gr_we,
                                           input logic [CSR_AW-1:0] csr_addr,
                                           input logic              csr_we);
    sb_entry_t e;
    e.rd       = rd;
    e.gr_we    = gr_we && (rd != '0);
    e.csr_addr = csr_addr;
    e.csr_we   = csr_we;
    return e;
  endfunction

endpackage

// File: rtl/rfu_scoreboard_match.sv
// Per-entry hazard comparator: flags a pending write to any queried operand.
module rfu_sb_match
  import rfu_scoreboard_pkg::*;
(
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              gr_we_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic              csr_we_i,
  input  logic [REG_AW-1:0] q_rs1_i,
  input  logic              q_rs1_re_i,
  input  logic [REG_AW-1:0] q_rs2_i,
  input  logic              q_rs2_re_i,
  input  logic [CSR_AW-1:0] q_csr_addr_i,
  input  logic              q_csr_re_i,
  output logic              hit_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic csr_hit;

  always_comb begin
    rs1_hit = gr_we_i && q_rs1_re_i && (rd_i == q_rs1_i) && (q_rs1_i != '0);
    rs2_hit = gr_we_i && q_rs2_re_i && (rd_i == q_rs2_i) && (q_rs2_i != '0);
    csr_hit = csr_we_i && q_csr_re_i && (csr_addr_i == q_csr_addr_i);
    hit_o   = valid_i && (rs1_hit || rs2_hit || csr_hit);
  end

endmodule

// File: rtl/riscv_param.vh
// Shared RISC-V architectural widths used across the core.
`ifndef RISCV_PARAM_VH
`define RISCV_PARAM_VH
`define RV_REG_AW 5
`define RV_CSR_AW 12
`endif

// File: rtl/rfu_scoreboard.sv
// In-order scoreboard of issued, not-yet-retired register/CSR writes.
module rfu_scoreboard
  import rfu_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue_valid_i,
  input  logic [REG_AW-1:0]        issue_rd_i,
  input  logic                     issue_gr_we_i,
  input  logic [CSR_AW-1:0]        issue_csr_addr_i,
  input  logic                     issue_csr_we_i,
  output logic                     issue_ready_o,
  input  logic                     commit_valid_i,
  input  logic                     flush_all_i,
  input  logic [REG_AW-1:0]        q_rs1_i,
  input  logic                     q_rs1_re_i,
  input  logic [REG_AW-1:0]        q_rs2_i,
  input  logic                     q_rs2_re_i,
  input  logic [CSR_AW-1:0]        q_csr_addr_i,
  input  logic                     q_csr_re_i,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        ent_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] hit;

  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == CW'(DEPTH));
    issue_ready_o = !full || commit_valid_i;
    push          = issue_valid_i && issue_ready_o;
    pop           = commit_valid_i && !empty;
  end

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;

    if (issue_valid_i && !issue_ready_o) err_d = 1'b1;
    if (commit_valid_i && empty)         err_d = 1'b1;

    if (flush_all_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pop is applied before push so a full-FIFO push+pop reusing the head slot ends valid.
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        ent_d[tail_q]   = make_entry(issue_rd_i, issue_gr_we_i,
                                     issue_csr_addr_i, issue_csr_we_i);
        tail_d          = tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload is qualified by valid_q alone, so it carries no reset.
  always_ff @(posedge clock) begin
    ent_q <= ent_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    rfu_sb_match u_match (
      .valid_i      (valid_q[g]),
      .rd_i         (ent_q[g].rd),
      .gr_we_i      (ent_q[g].gr_we),
      .csr_addr_i   (ent_q[g].csr_addr),
      .csr_we_i     (ent_q[g].csr_we),
      .q_rs1_i      (q_rs1_i),
      .q_rs1_re_i   (q_rs1_re_i),
      .q_rs2_i      (q_rs2_i),
      .q_rs2_re_i   (q_rs2_re_i),
      .q_csr_addr_i (q_csr_addr_i),
      .q_csr_re_i   (q_csr_re_i),
      .hit_o        (hit[g])
    );
  end

  assign stall_o = |hit;
  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rfu_scoreboard.sv
// Directed bench for rfu_scoreboard with hand-computed expectations (DEPTH=4).
module tb_rfu_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_gr_we_i;
  logic [11:0] issue_csr_addr_i;
  logic        issue_csr_we_i;
  logic        issue_ready_o;
  logic        commit_valid_i;
  logic        flush_all_i;
  logic [4:0]  q_rs1_i;
  logic        q_rs1_re_i;
  logic [4:0]  q_rs2_i;
  logic        q_rs2_re_i;
  logic [11:0] q_csr_addr_i;
  logic        q_csr_re_i;
  logic        stall_o;
  logic [2:0]  count_o;
  logic        err_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  rfu_scoreboard #(.DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid_i    (issue_valid_i),
    .issue_rd_i       (issue_rd_i),
    .issue_gr_we_i    (issue_gr_we_i),
    .issue_csr_addr_i (issue_csr_addr_i),
    .issue_csr_we_i   (issue_csr_we_i),
    .issue_ready_o    (issue_ready_o),
    .commit_valid_i   (commit_valid_i),
    .flush_all_i      (flush_all_i),
    .q_rs1_i          (q_rs1_i),
    .q_rs1_re_i       (q_rs1_re_i),
    .q_rs2_i          (q_rs2_i),
    .q_rs2_re_i       (q_rs2_re_i),
    .q_csr_addr_i     (q_csr_addr_i),
    .q_csr_re_i       (q_csr_re_i),
    .stall_o          (stall_o),
    .count_o          (count_o),
    .err_o            (err_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_rd_i       = '0;
    issue_gr_we_i    = 1'b0;
    issue_csr_addr_i = '0;
    issue_csr_we_i   = 1'b0;
    commit_valid_i   = 1'b0;
    flush_all_i      = 1'b0;
    q_rs1_i = '0; q_rs1_re_i = 1'b0;
    q_rs2_i = '0; q_rs2_re_i = 1'b0;
    q_csr_addr_i = '0; q_csr_re_i = 1'b0;
  endtask

  task automatic issue_gr(input logic [4:0] rd);
    issue_valid_i = 1'b1; issue_rd_i = rd; issue_gr_we_i = 1'b1;
    issue_csr_addr_i = '0; issue_csr_we_i = 1'b0;
  endtask

  task automatic query(input logic [4:0] rs1, input logic re1,
                       input logic [4:0] rs2, input logic re2,
                       input logic [11:0] csr, input logic rec);
    q_rs1_i = rs1; q_rs1_re_i = re1;
    q_rs2_i = rs2; q_rs2_re_i = re2;
    q_csr_addr_i = csr; q_csr_re_i = rec;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ready", 32'(issue_ready_o), 1);
    query(5'd5, 1'b1, 5'd5, 1'b1, 12'h341, 1'b1);
    chk("rst_stall", 32'(stall_o), 0);

    // rd=5 hazard, stays pending through its commit cycle
    idle(); issue_gr(5'd5); #1;
    chk("iss5_stall_same_cycle", 32'(stall_o), 0);
    tick(); idle();
    query(5'd5, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
    chk("rd5_stall", 32'(stall_o), 1);
    chk("rd5_count", 32'(count_o), 1);
    query(5'd6, 1'b1, 5'd5, 1'b0, 12'h0, 1'b0);
    chk("rd5_other_reg", 32'(stall_o), 0);
    query(5'd5, 1'b0, 5'd0, 1'b0, 12'h0, 1'b0);
    chk("rd5_re_low", 32'(stall_o), 0);
    query(5'd5, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
    commit_valid_i = 1'b1; #1;
    chk("rd5_commit_cycle_stall", 32'(stall_o), 1);
    tick(); commit_valid_i = 1'b0; #1;
    chk("rd5_after_commit", 32'(stall_o), 0);
    chk("rd5_after_count", 32'(count_o), 0);

    // x0 never hazards
    idle(); issue_gr(5'd0); tick(); idle();
    query(5'd0, 1'b1, 5'd0, 1'b1, 12'h0, 1'b0);
    chk("x0_stall", 32'(stall_o), 0);
    chk("x0_count", 32'(count_o), 1);
    commit_valid_i = 1'b1; tick(); idle(); #1;
    chk("x0_drain", 32'(count_o), 0);

    // CSR hazard
    issue_valid_i = 1'b1; issue_csr_addr_i = 12'h341; issue_csr_we_i = 1'b1;
    tick(); idle();
    query(5'd0, 1'b0, 5'd0, 1'b0, 12'h341, 1'b1);
    chk("csr341_stall", 32'(stall_o), 1);
    query(5'd0, 1'b0, 5'd0, 1'b0, 12'h300, 1'b1);
    chk("csr300_stall", 32'(stall_o), 0);
    commit_valid_i = 1'b1; tick(); idle(); #1;
    chk("csr_drain", 32'(count_o), 0);

    // fill to DEPTH, then push+pop when full, then overflow
    for (int i = 1; i <= 4; i++) begin
      idle(); issue_gr(5'(i)); tick();
    end
    idle(); #1;
    chk("full_count", 32'(count_o), 4);
    chk("full_ready", 32'(issue_ready_o), 0);
    query(5'd1, 1'b1, 5'd4, 1'b0, 12'h0, 1'b0);
    chk("full_rd1_stall", 32'(stall_o), 1);
    issue_gr(5'd7); commit_valid_i = 1'b1; #1;
    chk("full_pp_ready", 32'(issue_ready_o), 1);
    tick(); idle();
    chk("full_pp_count", 32'(count_o), 4);
    chk("full_pp_err", 32'(err_o), 0);
    query(5'd1, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
    chk("full_pp_rd1_gone", 32'(stall_o), 0);
    query(5'd0, 1'b0, 5'd7, 1'b1, 12'h0, 1'b0);
    chk("full_pp_rd7", 32'(stall_o), 1);
    query(5'd2, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
    chk("full_pp_rd2", 32'(stall_o), 1);
    idle(); issue_gr(5'd9); tick(); idle();
    chk("ovf_err", 32'(err_o), 1);
    chk("ovf_count", 32'(count_o), 4);
    query(5'd9, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
    chk("ovf_dropped", 32'(stall_o), 0);

    // mid-operation reset discards entries and clears err
    do_reset();
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_err", 32'(err_o), 0);
    chk("mid_rst_ready", 32'(issue_ready_o), 1);
    query(5'd2, 1'b1, 5'd7, 1'b1, 12'h0, 1'b0);
    chk("mid_rst_stall", 32'(stall_o), 0);

    // flush with simultaneous issue and commit
    idle(); issue_gr(5'd10); tick();
    idle(); issue_gr(5'd11); tick();
    idle(); issue_valid_i = 1'b1; issue_csr_addr_i = 12'h341; issue_csr_we_i = 1'b1; tick();
    idle(); #1;
    chk("pre_flush_count", 32'(count_o), 3);
    issue_gr(5'd12); commit_valid_i = 1'b1; flush_all_i = 1'b1;
    tick(); idle();
    chk("flush_count", 32'(count_o), 0);
    chk("flush_err", 32'(err_o), 0);
    query(5'd10, 1'b1, 5'd12, 1'b1, 12'h341, 1'b1);
    chk("flush_stall_a", 32'(stall_o), 0);
    query(5'd11, 1'b1, 5'd10, 1'b1, 12'h341, 1'b1);
    chk("flush_stall_b", 32'(stall_o), 0);

    // push+pop on empty: push accepted, pop ignored, err set
    idle(); issue_gr(5'd13); commit_valid_i = 1'b1; tick(); idle();
    chk("pp_empty_count", 32'(count_o), 1);
    chk("pp_empty_err", 32'(err_o), 1);
    query(5'd13, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
    chk("pp_empty_stall", 32'(stall_o), 1);

    // flush leaves the sticky error alone
    idle(); flush_all_i = 1'b1; tick(); idle(); #1;
    chk("flush_keeps_err", 32'(err_o), 1);
    chk("flush_keeps_cnt0", 32'(count_o), 0);

    do_reset();
    chk("rst2_err", 32'(err_o), 0);

    // commit on empty
    idle(); commit_valid_i = 1'b1; tick(); idle(); #1;
    chk("cmt_empty_err", 32'(err_o), 1);
    chk("cmt_empty_count", 32'(count_o), 0);
    do_reset();
    chk("rst3_err", 32'(err_o), 0);
    chk("rst3_count", 32'(count_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
